// File: rtl/prbs_pkg.sv
// Shared types and width constants for the PRBS generator sharing controller.
package prbs_pkg;

  localparam int NREQ_DEF = 4;
  localparam int LENW_DEF = 16;
  localparam int BYTE_W   = 8;
  localparam int PAT_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRIME,
    ST_STREAM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/prbs_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module prbs_rr_pick #(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PTRW-1:0] win_idx,
  output logic            any
);

  int j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any        = 1'b1;
        win_idx    = PTRW'(j);
        win_oh[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prbs_share_ctrl.sv
// Arbitrates one PRBS generator among NREQ requesters, one burst at a time.
module prbs_share_ctrl
  import prbs_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*PAT_W-1:0]  req_pattern,
  input  logic [NREQ*BYTE_W-1:0] req_n,
  input  logic [NREQ*LENW-1:0]   req_len,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   gen_rstn,
  output logic [PAT_W-1:0]       gen_pattern,
  output logic [BYTE_W-1:0]      gen_n,
  input  logic [BYTE_W-1:0]      gen_out,
  output logic [BYTE_W-1:0]      dout,
  output logic                   dout_valid
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] cur;
  logic [LENW-1:0] cnt;
  logic [NREQ-1:0] win_oh;
  logic [PTRW-1:0] win_idx;
  logic            any;
  logic [PTRW-1:0] ptr_nxt;

  prbs_rr_pick #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

  assign ptr_nxt = (int'(cur) == NREQ - 1) ? '0 : cur + 1'b1;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cur         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      gen_rstn    <= 1'b0;
      gen_pattern <= '0;
      gen_n       <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          // Config is captured once here so later input changes cannot disturb the burst.
          if (any) begin
            state       <= ST_LOAD;
            gnt         <= win_oh;
            cur         <= win_idx;
            gen_pattern <= req_pattern[int'(win_idx)*PAT_W +: PAT_W];
            gen_n       <= req_n[int'(win_idx)*BYTE_W +: BYTE_W];
            cnt         <= req_len[int'(win_idx)*LENW +: LENW];
          end
        end
        ST_LOAD: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            done  <= gnt;
            ptr   <= ptr_nxt;
          end else begin
            state    <= ST_PRIME;
            gen_rstn <= 1'b1;
          end
        end
        ST_PRIME: begin
          state <= ST_STREAM;
        end
        ST_STREAM: begin
          // The last capture coincides with the done pulse and the generator reset.
          dout       <= gen_out;
          dout_valid <= 1'b1;
          cnt        <= cnt - 1'b1;
          if (cnt == LENW'(1)) begin
            state    <= ST_DONE;
            done     <= gnt;
            gen_rstn <= 1'b0;
            ptr      <= ptr_nxt;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          gnt        <= '0;
          dout_valid <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_share_ctrl.sv
// Directed bench for prbs_share_ctrl with a behavioural model of the shared generator.
module tb_prbs_share_ctrl;

  localparam int NREQ = 4;
  localparam int LENW = 16;

  logic                 CLK = 1'b0;
  logic                 RSTn = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*32-1:0]   req_pattern = {NREQ{32'hDDCCBBAA}};
  logic [NREQ*8-1:0]    req_n = '0;
  logic [NREQ*LENW-1:0] req_len = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 gen_rstn;
  logic [31:0]          gen_pattern;
  logic [7:0]           gen_n;
  logic [7:0]           gen_out = 8'h00;
  logic [7:0]           dout;
  logic                 dout_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int gidx   = 0;
  logic [7:0] exp_b [16];

  prbs_share_ctrl #(.NREQ(NREQ), .LENW(LENW)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .req         (req),
    .req_pattern (req_pattern),
    .req_n       (req_n),
    .req_len     (req_len),
    .gnt         (gnt),
    .done        (done),
    .gen_rstn    (gen_rstn),
    .gen_pattern (gen_pattern),
    .gen_n       (gen_n),
    .gen_out     (gen_out),
    .dout        (dout),
    .dout_valid  (dout_valid)
  );

  always #5 CLK = ~CLK;

  // Generator model: pattern bytes LSB first, (n+1) times, then 11,22,33,...
  function automatic logic [7:0] gen_byte(input int k);
    int pre;
    logic [31:0] p;
    pre = 4 * (int'(gen_n) + 1);
    p   = gen_pattern;
    if (k < pre) return p[(k % 4) * 8 +: 8];
    return 8'(8'h11 * (k - pre + 1));
  endfunction

  always @(posedge CLK) begin
    if (!gen_rstn) begin
      gidx    <= 0;
      gen_out <= 8'h00;
    end else begin
      gen_out <= gen_byte(gidx);
      gidx    <= gidx + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_len(input int who, input int len);
    req_len[who*LENW +: LENW] = LENW'(len);
  endtask

  task automatic exp_default();
    logic [7:0] seq [10];
    seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 10; i++) exp_b[i] = seq[i];
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    req  = '0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
  endtask

  // Walks one burst from grant to the idle cycle after DONE, checking every cycle.
  task automatic run_burst(input int who, input int len, input bit clr, input bit scr);
    logic [NREQ-1:0]      oh;
    logic [NREQ*32-1:0]   sv_pat;
    logic [NREQ*8-1:0]    sv_n;
    logic [NREQ*LENW-1:0] sv_len;
    bit got;
    oh  = NREQ'(1) << who;
    got = 1'b0;
    sv_pat = req_pattern;
    sv_n   = req_n;
    sv_len = req_len;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (gnt != '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("grant_timeout", 64'd0, 64'd1);
      return;
    end
    chk("gnt_G", 64'(gnt), 64'(oh));
    chk("gen_rstn_G", 64'(gen_rstn), 64'd0);
    chk("valid_G", 64'(dout_valid), 64'd0);
    chk("gen_pattern_G", 64'(gen_pattern), 64'(req_pattern[who*32 +: 32]));
    @(negedge CLK);
    chk("gen_rstn_G1", 64'(gen_rstn), 64'(len != 0));
    chk("done_G1", 64'(done), (len == 0) ? 64'(oh) : 64'd0);
    chk("valid_G1", 64'(dout_valid), 64'd0);
    if (scr) begin
      req_pattern = ~req_pattern;
      req_n       = '1;
      req_len     = '1;
    end
    if (len != 0) begin
      @(negedge CLK);
      chk("gen_rstn_G2", 64'(gen_rstn), 64'd1);
      chk("valid_G2", 64'(dout_valid), 64'd0);
      chk("done_G2", 64'(done), 64'd0);
      for (int k = 0; k < len; k++) begin
        @(negedge CLK);
        chk("valid_stream", 64'(dout_valid), 64'd1);
        chk("dout_stream", 64'(dout), 64'(exp_b[k]));
        chk("done_stream", 64'(done), (k == len - 1) ? 64'(oh) : 64'd0);
        chk("gen_rstn_stream", 64'(gen_rstn), 64'(k < len - 1));
        chk("gnt_stream", 64'(gnt), 64'(oh));
      end
    end
    if (clr) req[who] = 1'b0;
    if (scr) begin
      req_pattern = sv_pat;
      req_n       = sv_n;
      req_len     = sv_len;
    end
    @(negedge CLK);
    chk("gnt_after", 64'(gnt), 64'd0);
    chk("done_after", 64'(done), 64'd0);
    chk("valid_after", 64'(dout_valid), 64'd0);
    chk("gen_rstn_after", 64'(gen_rstn), 64'd0);
    if (len != 0) chk("dout_hold", 64'(dout), 64'(exp_b[len-1]));
  endtask

  initial begin
    exp_default();
    // Reset state
    #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_gen_rstn", 64'(gen_rstn), 64'd0);
    chk("rst_gen_pattern", 64'(gen_pattern), 64'd0);
    chk("rst_gen_n", 64'(gen_n), 64'd0);
    do_reset();

    // Single burst, n=0, len=6, config scrambled mid-burst
    set_len(0, 6);
    req = 4'b0001;
    run_burst(0, 6, 1'b1, 1'b1);

    // n=1, len=8: preamble repeated twice
    do_reset();
    req_n[7:0] = 8'd1;
    set_len(0, 8);
    exp_b[4] = 8'hAA; exp_b[5] = 8'hBB; exp_b[6] = 8'hCC; exp_b[7] = 8'hDD;
    req = 4'b0001;
    run_burst(0, 8, 1'b1, 1'b0);
    chk("gen_n_latched", 64'(gen_n), 64'd1);
    req_n = '0;
    exp_default();

    // Two simultaneous requests
    do_reset();
    set_len(1, 2);
    set_len(3, 2);
    req = 4'b1010;
    run_burst(1, 2, 1'b1, 1'b0);
    run_burst(3, 2, 1'b1, 1'b0);

    // All requesters held, round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = 4'b1111;
    run_burst(0, 1, 1'b0, 1'b0);
    run_burst(1, 1, 1'b0, 1'b0);
    run_burst(2, 1, 1'b0, 1'b0);
    run_burst(3, 1, 1'b0, 1'b0);
    run_burst(0, 1, 1'b1, 1'b0);
    req = '0;

    // Zero-length burst
    do_reset();
    set_len(2, 0);
    req = 4'b0100;
    run_burst(2, 0, 1'b1, 1'b0);

    // Reset in the middle of a len=10 burst
    do_reset();
    set_len(0, 10);
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (gnt != '0) break;
    end
    repeat (4) @(negedge CLK);
    chk("mid_valid_before", 64'(dout_valid), 64'd1);
    #1 RSTn = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_valid", 64'(dout_valid), 64'd0);
    chk("mid_rst_dout", 64'(dout), 64'd0);
    chk("mid_rst_gen_rstn", 64'(gen_rstn), 64'd0);
    chk("mid_rst_gen_pattern", 64'(gen_pattern), 64'd0);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mid_rst_done", 64'(done), 64'd0);
    end
    RSTn = 1'b1;
    req  = 4'b0001;
    run_burst(0, 10, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/prbs_share_ctrl.md
PRBS_SHARE_CTRL -- requirements
Module: prbs_share_ctrl

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; LENW, default 16, burst length counter width.
REQ-002 CLK  input  1  clock; all logic SHALL be on the rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 req  input  NREQ  per-requester burst request, level; held until the matching done.
REQ-005 req_pattern  input  NREQ*32  per-requester 32-bit preamble pattern; slice i belongs to requester i.
REQ-006 req_n  input  NREQ*8  per-requester preamble repeat count.
REQ-007 req_len  input  NREQ*LENW  per-requester burst length in bytes.
REQ-008 gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-009 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 gen_rstn  output  1  reset to the shared PRBS generator, active-low.
REQ-011 gen_pattern  output  32  pattern driven to the generator.
REQ-012 gen_n  output  8  repeat count driven to the generator.
REQ-013 gen_out  input  8  generator byte output.
REQ-014 dout  output  8  byte stream to the granted requester.
REQ-015 dout_valid  output  1  dout qualifier; dout and dout_valid SHALL be driven directly from flops.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, PRIME, STREAM and DONE.
REQ-017 IDLE: when any req bit is set, the block SHALL pick a winner by round-robin and move to LOAD.
REQ-018 Round-robin: the winner SHALL be the first set req bit at or above the pointer, wrapping from NREQ-1 to 0; the pointer SHALL become winner+1 mod NREQ when the block enters DONE.
REQ-019 LOAD (grant cycle G): the block SHALL assert gnt for the winner, latch the winner's pattern, n and len, drive gen_rstn=0 and load the byte counter with len.
REQ-020 gen_pattern and gen_n SHALL hold the latched values from LOAD until the block leaves DONE.
REQ-021 LOAD with len==0: the block SHALL go directly to DONE, with no dout_valid pulse.
REQ-022 PRIME (G+1): gen_rstn=1; the generator's first byte SHALL be present on gen_out in G+2.
REQ-023 STREAM (G+2 .. G+1+len): the block SHALL register gen_out into dout with dout_valid=1 in the following cycle, decrement the counter each cycle, and go to DONE after the len-th byte is captured.
REQ-024 dout_valid SHALL be high for exactly len consecutive cycles, G+3 .. G+2+len, with no gaps; dout SHALL hold its last value while dout_valid=0.
REQ-025 DONE: done[winner] SHALL pulse in the same cycle as the last dout_valid (for len==0, in G+1); gnt SHALL drop in the next cycle, and the block SHALL return to IDLE.
REQ-026 gen_rstn SHALL be 0 in every state except PRIME and STREAM.
REQ-027 A req deasserted during a burst SHALL be ignored, and the burst SHALL complete.
REQ-028 A req held after done SHALL be eligible again only through round-robin.
REQ-029 Changes to the cfg inputs after LOAD SHALL have no effect on the current burst.
REQ-030 There SHALL be at least one idle cycle between bursts; back-to-back grants SHALL be separated by the DONE→IDLE cycle.

Reset
REQ-031 On RSTn low, the block SHALL immediately enter IDLE with: gnt=0, done=0, dout_valid=0, dout=8'h00, gen_rstn=0, gen_pattern=0, gen_n=0, pointer=0, counter=0.
REQ-032 A reset mid-burst SHALL abandon the burst with no done pulse; operation SHALL resume from IDLE on the first edge after RSTn rises.

Structure
REQ-033 Package prbs_pkg SHALL hold the FSM state enum, the NREQ and LENW defaults, and the byte and pattern width constants.
REQ-034 Sub-module prbs_rr_pick SHALL be a combinational round-robin picker: inputs req and pointer; outputs one-hot winner, winner index and any-valid.

Verification
REQ-035 req=4'b0001, pattern=32'hDDCCBBAA, n=0, len=6 -> dout AA,BB,CC,DD,11,22 in cycles G+3..G+8; done[0] in G+8.
REQ-036 req=4'b0001, n=1, len=8, same pattern -> AA,BB,CC,DD,AA,BB,CC,DD; gen_rstn low in G, high in G+1..G+9.
REQ-037 req=4'b1010 set in the same cycle, len=2 each -> gnt 4'b0010 burst first, then 4'b1000; no dout_valid overlap.
REQ-038 req=4'b1111 held continuously, len=1 -> grant order 0,1,2,3,0; every grant one-hot.
REQ-039 req=4'b0100 with len=0 -> done[2] in G+1, dout_valid never high, gen_rstn never high.
REQ-040 RSTn low at G+4 of a len=10 burst -> all outputs reset immediately, no done; a new req after release restarts from AA.
